// File: rtl/module_bcd_to_7seg_mux.sv
// Two-digit time-multiplexed 7-segment driver for packed BCD (tens [7:4], units [3:0]).
// Optional macro LEADING_ZERO_BLANK_EN blanks the tens digit when it is zero.
module module_bcd_to_7seg_mux #(
    parameter int REFRESH_DIV = 27000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] bcd_i,
    output logic [6:0] seg_o,
    output logic [1:0] an_o
);

    localparam int             CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic           POL     = (ACTIVE_LOW != 0);

    logic [CW-1:0] cnt;
    logic          tick;
    logic          dsel;
    logic [7:0]    bcd_q;
    logic [3:0]    digit;
    logic          blank;
    logic [6:0]    seg_raw;
    logic [1:0]    an_raw;

    assign tick = (cnt == CNT_MAX);

    // Prescaler and phase: dsel = 0 units, 1 tens. Data has no handshake;
    // bcd_i is sampled only on the tick that closes a tens phase.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt   <= '0;
            dsel  <= 1'b0;
            bcd_q <= 8'h00;
        end else begin
            if (tick) begin
                cnt  <= '0;
                dsel <= ~dsel;
                if (dsel) begin
                    bcd_q <= bcd_i;
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign digit = dsel ? bcd_q[7:4] : bcd_q[3:0];

`ifdef LEADING_ZERO_BLANK_EN
    assign blank = dsel && (bcd_q[7:4] == 4'd0);
`else
    assign blank = 1'b0;
`endif

    // Active-high {g,f,e,d,c,b,a}; non-decimal nibbles show a dash.
    always_comb begin
        seg_raw = 7'h40;
        an_raw  = dsel ? 2'b10 : 2'b01;
        case (digit)
            4'd0: seg_raw = 7'h3F;
            4'd1: seg_raw = 7'h06;
            4'd2: seg_raw = 7'h5B;
            4'd3: seg_raw = 7'h4F;
            4'd4: seg_raw = 7'h66;
            4'd5: seg_raw = 7'h6D;
            4'd6: seg_raw = 7'h7D;
            4'd7: seg_raw = 7'h07;
            4'd8: seg_raw = 7'h7F;
            4'd9: seg_raw = 7'h6F;
            default: seg_raw = 7'h40;
        endcase
        if (blank) begin
            seg_raw = 7'h00;
            an_raw  = 2'b00;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            seg_o <= {7{POL}};
            an_o  <= {2{POL}};
        end else begin
            seg_o <= seg_raw ^ {7{POL}};
            an_o  <= an_raw ^ {2{POL}};
        end
    end

endmodule

// File: tb/tb_module_bcd_to_7seg_mux.sv
// Bench for module_bcd_to_7seg_mux (REFRESH_DIV=4, ACTIVE_LOW=1): frame-level
// reference model, per-cycle compare, literal pins and randomized data/reset.
module tb_module_bcd_to_7seg_mux;

    localparam int DIV = 4;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] bcd_i = 8'h00;
    logic [6:0] seg_o;
    logic [1:0] an_o;

    module_bcd_to_7seg_mux #(.REFRESH_DIV(DIV), .ACTIVE_LOW(1)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bcd_i (bcd_i),
        .seg_o (seg_o),
        .an_o  (an_o)
    );

    always #5 clk_i = ~clk_i;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    // Model: n counts edges since reset release; the shown value is the one
    // captured at the last multiple of 2*DIV edges strictly before this edge.
    int         n       = 0;
    logic [7:0] mval    = 8'h00;
    logic [6:0] exp_seg = 7'h7F;
    logic [1:0] exp_an  = 2'b11;

    always @(posedge clk_i or posedge rst_i) begin
        int         phase;
        logic [3:0] dig;
        logic [6:0] enc;
        logic [1:0] an;
        if (rst_i) begin
            n       = 0;
            mval    = 8'h00;
            exp_seg = 7'h7F;
            exp_an  = 2'b11;
        end else begin
            n     = n + 1;
            phase = ((n - 1) / DIV) % 2;
            dig   = (phase == 1) ? mval[7:4] : mval[3:0];
            enc   = (dig <= 4'd9) ? seg_tab[dig] : 7'h40;
            an    = (phase == 1) ? 2'b10 : 2'b01;
            if (BLANK && phase == 1 && mval[7:4] == 4'd0) begin
                enc = 7'h00;
                an  = 2'b00;
            end
            exp_seg = ~enc;
            exp_an  = ~an;
            if (n % (2 * DIV) == 0) mval = bcd_i;
        end
    end

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got {seg,an}=%h required %h at t=%0t n=%0d", name, act, req, $time, n);
    endtask

    always @(negedge clk_i) begin
        check("model_cycle", {seg_o, an_o}, {exp_seg, exp_an});
    end

    task automatic wait_n(input int target);
        int guard = 0;
        while (n != target && guard < 200) begin
            @(negedge clk_i);
            guard++;
        end
        total_cnt++;
        if (n == target) pass_cnt++;
        else $display("FAIL wait_n: reached n=%0d required %0d", n, target);
    endtask

    initial begin
        logic [6:0] tens_zero_seg;
        logic [1:0] tens_zero_an;
        tens_zero_seg = BLANK ? 7'h7F : 7'h40;
        tens_zero_an  = BLANK ? 2'b11 : 2'b01;

        repeat (3) @(negedge clk_i);
        check("reset_hold", {seg_o, an_o}, {7'h7F, 2'b11});
        bcd_i = 8'h15;
        rst_i = 1'b0;

        wait_n(8);
        check("first_frame_tens00", {seg_o, an_o}, {tens_zero_seg, tens_zero_an});
        wait_n(9);  check("u5_start", {seg_o, an_o}, {7'h12, 2'b10});
        wait_n(12); check("u5_end",   {seg_o, an_o}, {7'h12, 2'b10});
        wait_n(13); check("t1_start", {seg_o, an_o}, {7'h79, 2'b01});
        wait_n(16); check("t1_end",   {seg_o, an_o}, {7'h79, 2'b01});
        wait_n(17); check("u5_repeat", {seg_o, an_o}, {7'h12, 2'b10});
        bcd_i = 8'h07;
        wait_n(21); check("no_tear_t1", {seg_o, an_o}, {7'h79, 2'b01});
        wait_n(25); check("u7", {seg_o, an_o}, {7'h78, 2'b10});
        wait_n(29); check("t0", {seg_o, an_o}, {tens_zero_seg, tens_zero_an});
        bcd_i = 8'hA3;
        wait_n(41); check("u3", {seg_o, an_o}, {7'h30, 2'b10});
        wait_n(45); check("t_dash", {seg_o, an_o}, {7'h3F, 2'b01});
        wait_n(46);
        #2 rst_i = 1'b1;
        #1 check("reset_async", {seg_o, an_o}, {7'h7F, 2'b11});
        @(negedge clk_i);
        rst_i = 1'b0;
        wait_n(1); check("post_rst_u0_a", {seg_o, an_o}, {7'h40, 2'b10});
        wait_n(4); check("post_rst_u0_b", {seg_o, an_o}, {7'h40, 2'b10});
        wait_n(5); check("post_rst_t0", {seg_o, an_o}, {tens_zero_seg, tens_zero_an});

        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_i);
            if ($urandom_range(0, 3) == 0) bcd_i = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 149) == 0) begin
                #2 rst_i = 1'b1;
                #1 check("rand_reset", {seg_o, an_o}, {7'h7F, 2'b11});
                repeat ($urandom_range(1, 3)) @(negedge clk_i);
                rst_i = 1'b0;
            end
        end

        @(negedge clk_i);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
